mem_dump: RTL and testbench

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump_pkg.sv | 27 ++
 rtl/mem_dump_if.sv | 35 +++
 rtl/mem_dump.sv | 170 +++++++++++++++++
 tb/tb_mem_dump.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared definitions for the data-memory dump engine: pipeline widths,
// default port widths and the dump FSM state encoding.
package mem_dump_pkg;

  // Widths shared with the rest of the pipeline
  localparam int XLEN        = 32;
  localparam int DMEM_ADDR_W = 12;

  // Default widths of the dump engine
  localparam int ADDR_W_DEF = DMEM_ADDR_W;
  localparam int DATA_W_DEF = XLEN;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

  // The engine counts as busy while a dump is in flight
  function automatic logic state_is_busy(input dump_state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/mem_dump_if.sv
// Bus bundle of the dump engine: the memory debug read port and the
// valid/ready word stream towards the consumer.
interface mem_dump_if #(
  parameter int ADDR_W = mem_dump_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_dump_pkg::DATA_W_DEF
);

  logic [ADDR_W-1:0] dbg_addr_o;
  logic [DATA_W-1:0] dbg_rdata_i;
  logic [DATA_W-1:0] word_o;
  logic [ADDR_W-1:0] addr_o;
  logic              valid_o;
  logic              ready_i;

  // Dump engine side
  modport master (
    output dbg_addr_o,
    input  dbg_rdata_i,
    output word_o,
    output addr_o,
    output valid_o,
    input  ready_i
  );

  // Memory model / consumer side
  modport slave (
    input  dbg_addr_o,
    output dbg_rdata_i,
    input  word_o,
    input  addr_o,
    input  valid_o,
    output ready_i
  );

endinterface

// File: rtl/mem_dump.sv
// Data-memory dump engine. On a rising edge of the retired-halt flag it
// walks word_cnt_i words starting at base_addr_i through the memory debug
// read port and streams each word with its byte address over valid/ready,
// accumulating a running checksum of the accepted words.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | armed, waiting for a 0->1 edge on halt_i
//   ISSUE   | debug read address driven for the current word
//   WAIT    | RD_LAT cycles of memory latency, address held stable
//   PRESENT | word/address offered with valid_o until ready_i
//   DONE    | dump finished (done_o pulsed on entry), wait for halt_i low
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              halt_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-2:0] word_cnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] checksum_o,
  mem_dump_if.master        bus
);

  localparam int         CNT_W     = ADDR_W - 1;
  // WAIT is left when the counter reaches zero, so it starts at RD_LAT-1
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  dump_state_e       state_q, state_d;
  logic              halt_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              done_q, done_d;

  logic              halt_rise;
  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W-1:0] addr_inc;
  logic [CNT_W-1:0]  cnt_dec;

  assign halt_rise    = halt_i & ~halt_q;
  assign base_aligned = base_addr_i & ~ADDR_W'(3);
  assign addr_inc     = addr_q + ADDR_W'(4);
  assign cnt_dec      = cnt_q - CNT_W'(1);

  // State register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values; everything holds unless a state acts
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    dbg_addr_d = dbg_addr_q;
    word_d     = word_q;
    out_addr_d = out_addr_q;
    csum_d     = csum_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (halt_rise) begin
          csum_d = '0;
          if (word_cnt_i != '0) begin
            addr_d     = base_aligned;
            cnt_d      = word_cnt_i;
            dbg_addr_d = base_aligned;
            state_d    = ST_ISSUE;
          end else begin
            // Empty dump: report completion without touching memory
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_ISSUE: begin
        wait_d  = WAIT_INIT;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_q == 2'd0) begin
          word_d     = bus.dbg_rdata_i;
          out_addr_d = addr_q;
          state_d    = ST_PRESENT;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end

      ST_PRESENT: begin
        if (bus.ready_i) begin
          csum_d = csum_q + word_q;
          addr_d = addr_inc;
          cnt_d  = cnt_dec;
          if (cnt_dec != '0) begin
            dbg_addr_d = addr_inc;
            state_d    = ST_ISSUE;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Re-arm only once halt drops, so a halt held high dumps once
        if (!halt_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers and the halt edge detector
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      halt_q     <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      dbg_addr_q <= '0;
      word_q     <= '0;
      out_addr_q <= '0;
      csum_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      halt_q     <= halt_i;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      dbg_addr_q <= dbg_addr_d;
      word_q     <= word_d;
      out_addr_q <= out_addr_d;
      csum_q     <= csum_d;
      done_q     <= done_d;
    end
  end

  assign bus.dbg_addr_o = dbg_addr_q;
  assign bus.word_o     = word_q;
  assign bus.addr_o     = out_addr_q;
  assign bus.valid_o    = (state_q == ST_PRESENT);
  assign busy_o         = state_is_busy(state_q);
  assign done_o         = done_q;
  assign checksum_o     = csum_q;

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump: memory model behind the debug port, a
// negedge monitor logging accepted words and done pulses, one task per scenario.
module tb_mem_dump;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          halt_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-2:0] word_cnt_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] checksum_o;

  int tests_run = 0;
  int tests_failed = 0;

  mem_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_dump #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk         (clk),
    .RST         (RST),
    .halt_i      (halt_i),
    .base_addr_i (base_addr_i),
    .word_cnt_i  (word_cnt_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .checksum_o  (checksum_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Memory with RL cycles of read latency
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    rd_pipe[0] <= mem[bus.dbg_addr_o[AW-1:2]];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.dbg_rdata_i = rd_pipe[RL-1];

  // Monitor: a word is transferred at the posedge following a negedge with valid&ready
  logic [DW-1:0] got_w [$];
  logic [AW-1:0] got_a [$];
  int done_pulses = 0;
  int valid_cycles = 0;

  always @(negedge clk) begin
    if (bus.valid_o && bus.ready_i) begin
      got_w.push_back(bus.word_o);
      got_a.push_back(bus.addr_o);
    end
    if (done_o) done_pulses++;
    if (bus.valid_o) valid_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    got_w.delete();
    got_a.delete();
    done_pulses = 0;
    valid_cycles = 0;
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW-2:0] cnt);
    base_addr_i = base;
    word_cnt_i  = cnt;
    halt_i      = 1'b1;
  endtask

  // Counts negedges until done_o is seen, bounded by budget
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done_o !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #2;
    tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0h want 0", bus.valid_o); end
    tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0h want 0", done_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0h want 0", busy_o); end
    tests_run++; if (bus.word_o !== 32'h0) begin tests_failed++; $display("FAIL reset_word: got %h want 0", bus.word_o); end
    tests_run++; if (bus.addr_o !== 12'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", bus.addr_o); end
    tests_run++; if (bus.dbg_addr_o !== 12'h0) begin tests_failed++; $display("FAIL reset_dbg_addr: got %h want 0", bus.dbg_addr_o); end
    tests_run++; if (checksum_o !== 32'h0) begin tests_failed++; $display("FAIL reset_checksum: got %h want 0", checksum_o); end
    @(posedge clk);
    #1 RST = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    int cyc;
    logic [DW-1:0] exp_w [3];
    logic [AW-1:0] exp_a [3];
    exp_w = '{32'd1, 32'd2, 32'd3};
    exp_a = '{12'h010, 12'h014, 12'h018};
    clear_log();
    bus.ready_i = 1'b1;
    start(12'h010, 11'd3);
    wait_done(100, cyc);
    tests_run++; if (cyc !== 11) begin tests_failed++; $display("FAIL basic_latency: got %0d cycles want 11", cyc); end
    tick(3);
    tests_run++; if (got_w.size() !== 3) begin tests_failed++; $display("FAIL basic_count: got %0d words want 3", got_w.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (got_w[i] !== exp_w[i]) begin tests_failed++; $display("FAIL basic_word%0d: got %h want %h", i, got_w[i], exp_w[i]); end
      tests_run++; if (got_a[i] !== exp_a[i]) begin tests_failed++; $display("FAIL basic_addr%0d: got %h want %h", i, got_a[i], exp_a[i]); end
    end
    tests_run++; if (checksum_o !== 32'd6) begin tests_failed++; $display("FAIL basic_checksum: got %h want 6", checksum_o); end
    tests_run++; if (done_pulses !== 1) begin tests_failed++; $display("FAIL basic_done_pulses: got %0d want 1", done_pulses); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_after: got %0h want 0", busy_o); end
    halt_i = 1'b0;
    tick(2);
  endtask

  task automatic test_stall();
    int cyc;
    clear_log();
    bus.ready_i = 1'b0;
    start(12'h010, 11'd3);
    cyc = 0;
    while (bus.valid_o !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++; if (bus.valid_o !== 1'b1) begin tests_failed++; $display("FAIL stall_first_valid: got %0h want 1", bus.valid_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++; if (bus.valid_o !== 1'b1) begin tests_failed++; $display("FAIL stall_valid_c%0d: got %0h want 1", i, bus.valid_o); end
      tests_run++; if (bus.word_o !== 32'd1) begin tests_failed++; $display("FAIL stall_word_c%0d: got %h want 1", i, bus.word_o); end
      tests_run++; if (bus.addr_o !== 12'h010) begin tests_failed++; $display("FAIL stall_addr_c%0d: got %h want 010", i, bus.addr_o); end
    end
    tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL stall_busy: got %0h want 1", busy_o); end
    @(posedge clk);
    #1 bus.ready_i = 1'b1;
    wait_done(100, cyc);
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL stall_done_timeout: got %0h want 1", done_o); end
    tick(3);
    tests_run++; if (got_w.size() !== 3) begin tests_failed++; $display("FAIL stall_count: got %0d words want 3", got_w.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (got_w[i] !== DW'(i + 1)) begin tests_failed++; $display("FAIL stall_word%0d: got %h want %h", i, got_w[i], DW'(i + 1)); end
    end
    tests_run++; if (checksum_o !== 32'd6) begin tests_failed++; $display("FAIL stall_checksum: got %h want 6", checksum_o); end
    tests_run++; if (done_pulses !== 1) begin tests_failed++; $display("FAIL stall_done_pulses: got %0d want 1", done_pulses); end
    halt_i = 1'b0;
    tick(2);
  endtask

  task automatic test_zero_cnt();
    int cyc;
    clear_log();
    start(12'h200, 11'd0);
    wait_done(20, cyc);
    tests_run++; if (cyc !== 2) begin tests_failed++; $display("FAIL zero_latency: got %0d cycles want 2", cyc); end
    tests_run++; if (checksum_o !== 32'h0) begin tests_failed++; $display("FAIL zero_checksum: got %h want 0", checksum_o); end
    tick(3);
    tests_run++; if (valid_cycles !== 0) begin tests_failed++; $display("FAIL zero_valid: got %0d valid cycles want 0", valid_cycles); end
    tests_run++; if (done_pulses !== 1) begin tests_failed++; $display("FAIL zero_done_pulses: got %0d want 1", done_pulses); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL zero_busy: got %0h want 0", busy_o); end
    halt_i = 1'b0;
    tick(2);
  endtask

  task automatic test_wrap();
    int cyc;
    clear_log();
    start(12'hFFC, 11'd2);
    wait_done(100, cyc);
    tests_run++; if (cyc !== 8) begin tests_failed++; $display("FAIL wrap_latency: got %0d cycles want 8", cyc); end
    tick(3);
    tests_run++; if (got_w.size() !== 2) begin tests_failed++; $display("FAIL wrap_count: got %0d words want 2", got_w.size()); end
    tests_run++; if (got_a[0] !== 12'hFFC) begin tests_failed++; $display("FAIL wrap_addr0: got %h want ffc", got_a[0]); end
    tests_run++; if (got_a[1] !== 12'h000) begin tests_failed++; $display("FAIL wrap_addr1: got %h want 000", got_a[1]); end
    tests_run++; if (got_w[0] !== 32'hA500_03FF) begin tests_failed++; $display("FAIL wrap_word0: got %h want a50003ff", got_w[0]); end
    tests_run++; if (got_w[1] !== 32'hA500_0000) begin tests_failed++; $display("FAIL wrap_word1: got %h want a5000000", got_w[1]); end
    tests_run++; if (checksum_o !== 32'h4A00_03FF) begin tests_failed++; $display("FAIL wrap_checksum: got %h want 4a0003ff", checksum_o); end
    halt_i = 1'b0;
    tick(2);
  endtask

  task automatic test_unaligned();
    int cyc;
    clear_log();
    start(12'h013, 11'd1);
    wait_done(50, cyc);
    tests_run++; if (cyc !== 5) begin tests_failed++; $display("FAIL unal_latency: got %0d cycles want 5", cyc); end
    tick(2);
    tests_run++; if (got_a[0] !== 12'h010) begin tests_failed++; $display("FAIL unal_addr: got %h want 010", got_a[0]); end
    tests_run++; if (got_w[0] !== 32'd1) begin tests_failed++; $display("FAIL unal_word: got %h want 1", got_w[0]); end
    tests_run++; if (checksum_o !== 32'd1) begin tests_failed++; $display("FAIL unal_checksum: got %h want 1", checksum_o); end
    halt_i = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_log();
    start(12'h100, 11'd4);
    cyc = 0;
    while (got_w.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++; if (got_w.size() !== 2) begin tests_failed++; $display("FAIL rstmid_reach2: got %0d words want 2", got_w.size()); end
    @(posedge clk);
    #1 RST = 1'b1;
    #1;
    tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid: got %0h want 0", bus.valid_o); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %0h want 0", busy_o); end
    tests_run++; if (bus.word_o !== 32'h0) begin tests_failed++; $display("FAIL rstmid_word: got %h want 0", bus.word_o); end
    tests_run++; if (bus.addr_o !== 12'h0) begin tests_failed++; $display("FAIL rstmid_addr: got %h want 0", bus.addr_o); end
    tests_run++; if (bus.dbg_addr_o !== 12'h0) begin tests_failed++; $display("FAIL rstmid_dbg_addr: got %h want 0", bus.dbg_addr_o); end
    tests_run++; if (checksum_o !== 32'h0) begin tests_failed++; $display("FAIL rstmid_checksum: got %h want 0", checksum_o); end
    tick(2);
    tests_run++; if (done_pulses !== 0) begin tests_failed++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_pulses); end
    clear_log();
    // halt_i is still high: release must restart the dump from base
    RST = 1'b0;
    wait_done(100, cyc);
    tests_run++; if (cyc !== 14) begin tests_failed++; $display("FAIL rstmid_restart_latency: got %0d cycles want 14", cyc); end
    tick(3);
    tests_run++; if (got_w.size() !== 4) begin tests_failed++; $display("FAIL rstmid_count: got %0d words want 4", got_w.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (got_a[i] !== AW'(12'h100 + 4 * i)) begin tests_failed++; $display("FAIL rstmid_addr%0d: got %h want %h", i, got_a[i], AW'(12'h100 + 4 * i)); end
      tests_run++; if (got_w[i] !== DW'(32'hA500_0040 + i)) begin tests_failed++; $display("FAIL rstmid_word%0d: got %h want %h", i, got_w[i], DW'(32'hA500_0040 + i)); end
    end
    tests_run++; if (checksum_o !== 32'h9400_0106) begin tests_failed++; $display("FAIL rstmid_checksum_end: got %h want 94000106", checksum_o); end
    tests_run++; if (done_pulses !== 1) begin tests_failed++; $display("FAIL rstmid_done_pulses: got %0d want 1", done_pulses); end
  endtask

  task automatic test_rearm();
    int cyc;
    // halt_i is still high from the previous dump
    clear_log();
    tick(20);
    tests_run++; if (valid_cycles !== 0) begin tests_failed++; $display("FAIL rearm_no_second_valid: got %0d want 0", valid_cycles); end
    tests_run++; if (done_pulses !== 0) begin tests_failed++; $display("FAIL rearm_no_second_done: got %0d want 0", done_pulses); end
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL rearm_busy: got %0h want 0", busy_o); end
    tests_run++; if (checksum_o !== 32'h9400_0106) begin tests_failed++; $display("FAIL rearm_checksum_hold: got %h want 94000106", checksum_o); end
    halt_i = 1'b0;
    tick(2);
    clear_log();
    halt_i = 1'b1;
    wait_done(100, cyc);
    tests_run++; if (cyc !== 14) begin tests_failed++; $display("FAIL rearm_latency: got %0d cycles want 14", cyc); end
    tick(3);
    tests_run++; if (got_w.size() !== 4) begin tests_failed++; $display("FAIL rearm_count: got %0d words want 4", got_w.size()); end
    tests_run++; if (checksum_o !== 32'h9400_0106) begin tests_failed++; $display("FAIL rearm_checksum: got %h want 94000106", checksum_o); end
    tests_run++; if (done_pulses !== 1) begin tests_failed++; $display("FAIL rearm_done_pulses: got %0d want 1", done_pulses); end
    halt_i = 1'b0;
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | DW'(i);
    mem[4] = 32'd1;
    mem[5] = 32'd2;
    mem[6] = 32'd3;
    bus.ready_i = 1'b0;

    test_reset();
    test_basic();
    test_stall();
    test_zero_cnt();
    test_wrap();
    test_unaligned();
    test_reset_mid();
    test_rearm();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
